// File: rtl/pipe_ctrl_unit_if.sv
// Control-path bundle between the ID stage and the pipelined control unit.
// The master drives the ID-stage fields and the flush request.
// The slave (the control unit) returns the stall request and the per-stage controls.
interface pipe_ctrl_unit_if #(
  parameter int OP_W   = 6,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [OP_W-1:0]   id_op;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              ex_flush;
  logic              stall;
  logic              ex_reg_dst;
  logic              ex_alu_src;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_ext_op;
  logic [1:0]        ex_alu_op;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              illegal;

  modport master (
    output id_valid, id_op, id_rs, id_rt, ex_flush,
    input  stall, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_ext_op,
           ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write,
           wb_mem_to_reg, illegal
  );

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, ex_flush,
    output stall, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_ext_op,
           ex_alu_op, mem_mem_read, mem_mem_write, wb_reg_write,
           wb_mem_to_reg, illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS-subset core.
// It decodes the ID opcode and carries the controls through the ID/EX, EX/MEM and MEM/WB registers.
// It detects load-use hazards (stall) and turns stalled, flushed, invalid or unknown ops into bubbles.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, the sticky illegal flag is set
// when an illegal opcode is accepted. When it is undefined, the flag is tied to 0.
module pipe_ctrl_unit #(
  parameter int OP_W   = 6,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000101;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       ext_op;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  logic [5:0]        op_lo_s;
  logic              op_hi_s;
  logic              is_illegal_s;
  logic              uses_rt_s;
  ctrl_t             dec_s;
  ctrl_t             ctrl_id_s;
  logic              hazard_s;
  logic              stall_s;

  ctrl_t             idex_r;
  logic [REG_AW-1:0] idex_rt_r;
  logic              exmem_mem_read_r;
  logic              exmem_mem_write_r;
  logic              exmem_reg_write_r;
  logic              exmem_mem_to_reg_r;
  logic              memwb_reg_write_r;
  logic              memwb_mem_to_reg_r;
  logic              illegal_r;

  // Any opcode bit above bit 5 makes the opcode illegal. The shift stays legal when OP_W is 6.
  assign op_lo_s = bus.id_op[5:0];
  assign op_hi_s = ((bus.id_op >> 6) != {OP_W{1'b0}});

  // Opcode decode. Unknown opcodes decode to all-zero fields and are marked illegal.
  always_comb begin
    dec_s        = '0;
    uses_rt_s    = 1'b0;
    is_illegal_s = 1'b0;
    if (op_hi_s) begin
      is_illegal_s = 1'b1;
    end else begin
      case (op_lo_s)
        OP_RTYPE: begin
          dec_s.reg_dst   = 1'b1;
          dec_s.reg_write = 1'b1;
          dec_s.alu_op    = 2'b00;
          uses_rt_s       = 1'b1;
        end
        OP_ADDI: begin
          dec_s.alu_src   = 1'b1;
          dec_s.reg_write = 1'b1;
          dec_s.alu_op    = 2'b01;
        end
        OP_LW: begin
          dec_s.alu_src    = 1'b1;
          dec_s.mem_to_reg = 1'b1;
          dec_s.reg_write  = 1'b1;
          dec_s.mem_read   = 1'b1;
          dec_s.ext_op     = 1'b1;
          dec_s.alu_op     = 2'b01;
        end
        OP_SW: begin
          dec_s.alu_src   = 1'b1;
          dec_s.mem_write = 1'b1;
          dec_s.ext_op    = 1'b1;
          dec_s.alu_op    = 2'b01;
          uses_rt_s       = 1'b1;
        end
        OP_BEQ: begin
          dec_s.branch = 1'b1;
          dec_s.alu_op = 2'b10;
          uses_rt_s    = 1'b1;
        end
        OP_J: begin
          dec_s.jump   = 1'b1;
          dec_s.alu_op = 2'b00;
        end
        default: begin
          is_illegal_s = 1'b1;
        end
      endcase
    end
  end

  // An invalid slot or an illegal opcode presents a bubble to ID/EX.
  always_comb begin
    ctrl_id_s = '0;
    if (bus.id_valid && !is_illegal_s) begin
      ctrl_id_s = dec_s;
    end else begin
      ctrl_id_s = '0;
    end
  end

  // Load-use hazard: the load in EX writes a register that the ID op reads. Register 0 never conflicts.
  assign hazard_s = bus.id_valid & idex_r.mem_read & (idex_rt_r != {REG_AW{1'b0}}) &
                    ((idex_rt_r == bus.id_rs) | ((idex_rt_r == bus.id_rt) & uses_rt_s));
  // A flush squashes the ID op anyway, so it suppresses the stall request.
  assign stall_s  = hazard_s & ~bus.ex_flush;
  assign bus.stall = stall_s;

  // ID/EX register. A flush or a stall loads a bubble. Otherwise it captures the decoded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_r    <= '0;
      idex_rt_r <= {REG_AW{1'b0}};
    end else if (bus.ex_flush || stall_s) begin
      idex_r    <= '0;
      idex_rt_r <= {REG_AW{1'b0}};
    end else begin
      idex_r    <= ctrl_id_s;
      idex_rt_r <= bus.id_rt;
    end
  end

  // EX/MEM register. It advances every cycle and carries only the mem and wb fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_mem_read_r   <= 1'b0;
      exmem_mem_write_r  <= 1'b0;
      exmem_reg_write_r  <= 1'b0;
      exmem_mem_to_reg_r <= 1'b0;
    end else begin
      exmem_mem_read_r   <= idex_r.mem_read;
      exmem_mem_write_r  <= idex_r.mem_write;
      exmem_reg_write_r  <= idex_r.reg_write;
      exmem_mem_to_reg_r <= idex_r.mem_to_reg;
    end
  end

  // MEM/WB register. It advances every cycle and carries only the wb fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_reg_write_r  <= 1'b0;
      memwb_mem_to_reg_r <= 1'b0;
    end else begin
      memwb_reg_write_r  <= exmem_reg_write_r;
      memwb_mem_to_reg_r <= exmem_mem_to_reg_r;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic accept_s;
  assign accept_s = bus.id_valid & ~stall_s & ~bus.ex_flush;

  // Sticky illegal flag. It is set only when an illegal op is accepted, never when it is stalled or flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (accept_s && is_illegal_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end
`else
  // Without the trap, the illegal flag stays cleared. Illegal ops still decode as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
    end
  end
`endif

  assign bus.ex_reg_dst    = idex_r.reg_dst;
  assign bus.ex_alu_src    = idex_r.alu_src;
  assign bus.ex_branch     = idex_r.branch;
  assign bus.ex_jump       = idex_r.jump;
  assign bus.ex_ext_op     = idex_r.ext_op;
  assign bus.ex_alu_op     = idex_r.alu_op;
  assign bus.mem_mem_read  = exmem_mem_read_r;
  assign bus.mem_mem_write = exmem_mem_write_r;
  assign bus.wb_reg_write  = memwb_reg_write_r;
  assign bus.wb_mem_to_reg = memwb_mem_to_reg_r;
  assign bus.illegal       = illegal_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit.
// Instance a uses the default 6-bit opcode. Instance b uses OP_W=8.
// Expected ID/EX words go into a scoreboard queue. The EX, MEM and WB stage values are popped from that queue.
module tb_pipe_ctrl_unit;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected ID/EX words, oldest first: [MEM/WB, EX/MEM, ID/EX].
  // Bit order: reg_dst alu_src branch jump ext_op alu_op[1:0] mem_read mem_write reg_write mem_to_reg
  logic [10:0] sb[$];
  logic        exp_illegal;

  pipe_ctrl_unit_if #(.OP_W(6), .REG_AW(5)) a ();
  pipe_ctrl_unit_if #(.OP_W(8), .REG_AW(5)) b ();

  pipe_ctrl_unit #(.OP_W(6), .REG_AW(5)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  pipe_ctrl_unit #(.OP_W(8), .REG_AW(5)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Control word for each opcode, taken from the opcode table.
  function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:    return 11'b1_0_0_0_0_00_0_0_1_0;
      6'd1:    return 11'b0_1_0_0_0_01_0_0_1_0;
      6'd2:    return 11'b0_1_0_0_1_01_1_0_1_1;
      6'd3:    return 11'b0_1_0_0_1_01_0_1_0_0;
      6'd4:    return 11'b0_0_1_0_0_10_0_0_0_0;
      6'd5:    return 11'b0_0_0_1_0_00_0_0_0_0;
      default: return 11'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares all stage outputs of instance a with the scoreboard.
  task automatic check_stages(input string tag);
    logic [10:0] w_ex, w_mem, w_wb;
    w_wb  = sb[0];
    w_mem = sb[1];
    w_ex  = sb[2];
    chk({tag, "/ex"}, {25'd0, a.ex_reg_dst, a.ex_alu_src, a.ex_branch, a.ex_jump,
                       a.ex_ext_op, a.ex_alu_op}, {25'd0, w_ex[10:4]});
    chk({tag, "/mem"}, {30'd0, a.mem_mem_read, a.mem_mem_write}, {30'd0, w_mem[3:2]});
    chk({tag, "/wb"}, {30'd0, a.wb_reg_write, a.wb_mem_to_reg}, {30'd0, w_wb[1:0]});
    chk({tag, "/illegal"}, {31'd0, a.illegal}, {31'd0, exp_illegal});
  endtask

  task automatic idle_inputs();
    a.id_valid = 1'b0; a.id_op = 6'd0; a.id_rs = 5'd0; a.id_rt = 5'd0; a.ex_flush = 1'b0;
    b.id_valid = 1'b0; b.id_op = 8'd0; b.id_rs = 5'd0; b.id_rt = 5'd0; b.ex_flush = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb = {11'd0, 11'd0, 11'd0};
    exp_illegal = 1'b0;
    check_stages(tag);
    chk({tag, "/stall"}, {31'd0, a.stall}, 32'd0);
    chk({tag, "/b_ex"}, {26'd0, b.ex_reg_dst, b.ex_alu_src, b.ex_branch, b.ex_jump, b.ex_ext_op,
                         b.ex_alu_op, b.mem_mem_read}, 32'd0);
  endtask

  // Presents one ID slot to instance a, checks stall in the same cycle, then checks the stages after the edge.
  task automatic step(input string tag, input bit v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input bit fl, input bit exp_stall);
    logic [10:0] w;
    logic [10:0] popped;
    a.id_valid = v; a.id_op = op; a.id_rs = rs; a.id_rt = rt; a.ex_flush = fl;
    #1;
    chk({tag, "/stall"}, {31'd0, a.stall}, {31'd0, exp_stall});
    if (!v || fl || exp_stall) w = 11'd0;
    else w = ref_ctrl(op);
    if (TRAP && v && !fl && !exp_stall && (op > 6'd5)) exp_illegal = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(w);
    popped = sb.pop_front();
    check_stages(tag);
  endtask

  initial begin
    idle_inputs();
    do_reset("reset0");

    // Stream every supported op. wb_reg_write should arrive as 1,1,1,0,0,0.
    step("s_r",    1'b1, 6'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("s_addi", 1'b1, 6'd1, 5'd1, 5'd2, 1'b0, 1'b0);
    step("s_lw",   1'b1, 6'd2, 5'd1, 5'd3, 1'b0, 1'b0);
    step("s_sw",   1'b1, 6'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    step("s_beq",  1'b1, 6'd4, 5'd4, 5'd6, 1'b0, 1'b0);
    step("s_j",    1'b1, 6'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    step("drain1", 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("drain2", 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("drain3", 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Load-use on rs: one stall cycle. The re-presented op then proceeds.
    step("lu_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("lu_r",    1'b1, 6'd0, 5'd5, 5'd7, 1'b0, 1'b1);
    step("lu_r2",   1'b1, 6'd0, 5'd5, 5'd7, 1'b0, 1'b0);
    // Load into r0 never stalls.
    step("z_lw",    1'b1, 6'd2, 5'd1, 5'd0, 1'b0, 1'b0);
    step("z_r",     1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    // addi does not read its rt field.
    step("ad_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("ad_addi", 1'b1, 6'd1, 5'd1, 5'd5, 1'b0, 1'b0);
    // sw and R-type read rt.
    step("sw_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("sw_sw",   1'b1, 6'd3, 5'd1, 5'd5, 1'b0, 1'b1);
    step("sw_sw2",  1'b1, 6'd3, 5'd1, 5'd5, 1'b0, 1'b0);
    step("rt_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("rt_r",    1'b1, 6'd0, 5'd2, 5'd5, 1'b0, 1'b1);
    step("rt_r2",   1'b1, 6'd0, 5'd2, 5'd5, 1'b0, 1'b0);
    // An invalid ID slot never stalls.
    step("iv_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("iv_r",    1'b0, 6'd0, 5'd5, 5'd5, 1'b0, 1'b0);
    // Flush wins over stall: no stall request, and ID/EX gets a bubble.
    step("fl_lw",   1'b1, 6'd2, 5'd1, 5'd5, 1'b0, 1'b0);
    step("fl_r",    1'b1, 6'd0, 5'd5, 5'd7, 1'b1, 1'b0);
    step("fl_nop",  1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Illegal ops that are flushed or stalled do not set the flag. An accepted one does, when the trap is built in.
    step("il_flush", 1'b1, 6'h3f, 5'd0, 5'd0, 1'b1, 1'b0);
    step("il_lw",    1'b1, 6'd2,  5'd1, 5'd5, 1'b0, 1'b0);
    step("il_stall", 1'b1, 6'h3f, 5'd5, 5'd0, 1'b0, 1'b1);
    step("il_acc",   1'b1, 6'h3f, 5'd0, 5'd0, 1'b0, 1'b0);
    step("il_r",     1'b1, 6'd0,  5'd1, 5'd2, 1'b0, 1'b0);
    step("il_unk",   1'b1, 6'h06, 5'd1, 5'd2, 1'b0, 1'b0);
    step("il_nop1",  1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 1'b0);
    step("il_nop2",  1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 1'b0);

    // A reset while a lw sits in EX/MEM discards it. The reset also clears illegal.
    step("rs_lw",   1'b1, 6'd2, 5'd1, 5'd3, 1'b0, 1'b0);
    step("rs_nop",  1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    do_reset("reset_mid");

    // Wide-opcode instance: 8'h02 is lw, 8'h42 is illegal.
    b.id_valid = 1'b1; b.id_op = 8'h02; b.id_rs = 5'd0; b.id_rt = 5'd0; b.ex_flush = 1'b0;
    #1;
    chk("w_stall0", {31'd0, b.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("w_lw_ex", {25'd0, b.ex_reg_dst, b.ex_alu_src, b.ex_branch, b.ex_jump, b.ex_ext_op,
                    b.ex_alu_op}, {25'd0, 7'b0_1_0_0_1_01});
    chk("w_lw_ill", {31'd0, b.illegal}, 32'd0);
    b.id_op = 8'h42;
    @(posedge clk);
    #1;
    chk("w_42_ex", {25'd0, b.ex_reg_dst, b.ex_alu_src, b.ex_branch, b.ex_jump, b.ex_ext_op,
                    b.ex_alu_op}, 32'd0);
    chk("w_lw_mem", {30'd0, b.mem_mem_read, b.mem_mem_write}, 32'd2);
    chk("w_42_ill", {31'd0, b.illegal}, {31'd0, TRAP});
    b.id_valid = 1'b0; b.id_op = 8'h00;
    @(posedge clk);
    #1;
    chk("w_lw_wb", {30'd0, b.wb_reg_write, b.wb_mem_to_reg}, 32'd3);
    chk("w_42_mem", {30'd0, b.mem_mem_read, b.mem_mem_write}, 32'd0);
    @(posedge clk);
    #1;
    chk("w_42_wb", {30'd0, b.wb_reg_write, b.wb_mem_to_reg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage MIPS-subset core. It decodes the ID-stage opcode and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers, so each stage gets its own aligned controls. It detects load-use hazards and raises `stall`, inserts bubbles on stall or flush, and decodes every unknown opcode as a NOP. Opcode width and register-address width are parameters.

## Interface
Parameters:
- `OP_W`, 6, opcode width; must be ≥ 6. If any opcode bit above bit 5 is set, the opcode is illegal.
- `REG_AW`, 5, register-address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  IF/ID holds a valid instruction.
- `id_op`  in  OP_W  opcode in ID.
- `id_rs`  in  REG_AW  rs field in ID.
- `id_rt`  in  REG_AW  rt field in ID.
- `ex_flush`  in  1  branch/jump resolved in EX; squash the instruction in ID.
- `stall`  out  1  hold PC and IF/ID (combinational).
- `ex_reg_dst`, `ex_alu_src`, `ex_branch`, `ex_jump`, `ex_ext_op`  out  1 each  EX-stage controls.
- `ex_alu_op`  out  2  EX-stage ALU op.
- `mem_mem_read`, `mem_mem_write`  out  1 each  MEM-stage controls.
- `wb_reg_write`, `wb_mem_to_reg`  out  1 each  WB-stage controls.
- `illegal`  out  1  sticky illegal-opcode flag.

## Operation
Decode (combinational, ID). Each opcode sets the fields listed; every field not listed is 0.
- 000000, R-type: reg_dst, reg_write; alu_op=00.
- 000001, addi: alu_src, reg_write; alu_op=01; ext_op=0.
- 000010, lw: alu_src, mem_to_reg, reg_write, mem_read, ext_op; alu_op=01.
- 000011, sw: alu_src, mem_write, ext_op; alu_op=01.
- 000100, beq: branch; alu_op=10.
- 000101, j: jump; alu_op=00.
- Any other opcode, or `id_valid`=0: all fields 0 (bubble).
- No output is ever X or latched.

Pipeline:
- ID/EX captures the decoded word plus `id_rt`.
- EX/MEM captures the mem and wb fields from ID/EX.
- MEM/WB captures the wb fields from EX/MEM.
- EX/MEM and MEM/WB advance every cycle. They are never stalled.

Load-use hazard:
- `stall` = `id_valid` & ID/EX.mem_read & (ID/EX.rt ≠ 0) & (ID/EX.rt == `id_rs`, or (ID/EX.rt == `id_rt` and the ID op is R-type, sw or beq)).
- When `stall`=1, ID/EX loads a bubble. The ID instruction is re-presented by the surrounding logic next cycle.

Flush:
- When `ex_flush`=1, ID/EX loads a bubble and `stall` is forced to 0.
- Flush has priority over stall.

## Timing
- Reset (synchronous, next edge): all pipeline registers cleared, so every `ex_*`, `mem_*` and `wb_*` output is 0.
- After reset, `illegal`=0 and `stall`=0.
- Reset mid-stream discards all in-flight controls in the same edge.
- Latency from an op accepted in ID at edge N:
  - `ex_*` valid after edge N+1.
  - `mem_*` valid after edge N+2.
  - `wb_*` valid after edge N+3.
- `stall` is combinational from the `id_*` inputs and the ID/EX register, in the same cycle.
- A stall lasts exactly one cycle per load-use pair. The cycle after, ID/EX holds a bubble, so the stall condition clears.
- `rst` overrides `ex_flush` and `stall`.
- An ID op counts as accepted when `id_valid`=1, `stall`=0 and `ex_flush`=0.

## Configuration
`CTRL_ILLEGAL_TRAP_EN`:
- Defined: on the edge an illegal opcode is accepted, `illegal` is set. It then stays 1 until `rst`. An illegal op that is stalled or flushed does not set it.
- Undefined: `illegal` is tied 0.
- In both cases an illegal opcode is decoded as a bubble.

## Test plan
- Reset, then stream R, addi, lw, sw, beq, j with `id_valid`=1.
  - At each EX output, check: reg_dst=1 for R; alu_op 00/01/01/01/10/00; ext_op 0/0/1/1/0/0; `stall`=0 throughout.
  - `wb_reg_write` must be 1, 1, 1, 0, 0, 0 at edges N+3 respectively.
- lw with rt=5 in EX, then R-type with rs=5 in ID → `stall`=1 for one cycle and all `ex_*`=0 next cycle.
  - Repeat with rt=0 → no stall.
  - Repeat with addi where rt=5 matches only its rt field → no stall.
- Hold `stall`=1 and `ex_flush`=1 in the same cycle → `stall`=0 and ID/EX gets a bubble.
- `id_op`=6'b111111 accepted:
  - With `CTRL_ILLEGAL_TRAP_EN`: `illegal` goes to 1 on the next edge, stays 1 until `rst`, and all downstream controls stay 0.
  - Without the macro: `illegal` stays 0.
- Assert `rst` while lw sits in EX/MEM → `mem_mem_read`=0 and `wb_*`=0 on the next edge.
- `OP_W`=8 with `id_op`=8'h02 → decoded as lw; `id_op`=8'h42 → illegal.
